mult_sequencer: RTL and testbench

- Multi-cycle controller for the radix-2 Booth shift-add multiplier built from the ALU, the hi/lo universal shifters, the lo[-1] flip-flop and the mod-32 down counter.
- On a `mult` (R-type, funct 0x18), it drives the multiply control fields cycle by cycle.
- It stalls the PC until the 64-bit product sits in {hi,lo}.
- Its state code `mulst` feeds back to ALU control, which selects this block's fields as the control word during `mult`.

---
 rtl/mult_sequencer.sv | 174 +++++++++++++++++
 tb/tb_mult_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mult_sequencer
// Description : Multi-cycle controller for the radix-2 Booth shift-add
//               multiplier. The multiplier is built from the ALU, the hi/lo
//               universal shifters, the lo[-1] flip-flop and a down counter.
//               On a decoded `mult` it loads the operands, then runs WIDTH
//               evaluate/shift pairs. The PC is stalled until the 64-bit
//               product sits in {hi,lo}.
//
// Ports       : clk       system clock, rising edge
//               rst_n     asynchronous active-low reset
//               start     decoded mult (level, held while instruction current)
//               flush     synchronous abort to IDLE (exception)
//               lo0       current lo[0]
//               lo_m1     current lo[-1] flip-flop value
//               mulst     state code (IDLE=0 LOAD=1 EVAL=2 SHIFT=3 DONE=4)
//               alu_sel   ALU selector (010 add, 110 sub, 000 hold)
//               hi_sel    1 selects hi as ALU operand A
//               lom1_ctl  lo[-1] ctl (00 hold, 01 clear, 10 load lo[0])
//               lo_ctl    lo shifter ctl (000 hold, 001 load rt,
//                         010 shift right with serial-in hi[0], 011 clear)
//               hi_ctl    hi shifter ctl (000 hold, 001 load ALU,
//                         010 arithmetic shift right, 011 clear)
//               pc_we     PC write enable
//               busy      high in LOAD, EVAL, SHIFT
//               done      one-cycle pulse in DONE
//
// Revision    : 1.0  initial release
// ============================================================================
module mult_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       flush,
    input  logic       lo0,
    input  logic       lo_m1,
    output logic [2:0] mulst,
    output logic [2:0] alu_sel,
    output logic       hi_sel,
    output logic [1:0] lom1_ctl,
    output logic [2:0] lo_ctl,
    output logic [2:0] hi_ctl,
    output logic       pc_we,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_EVAL  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [2:0]       c_ALU_ADD   = 3'b010;
    localparam logic [2:0]       c_ALU_SUB   = 3'b110;
    localparam logic [2:0]       c_SH_LOAD   = 3'b001;
    localparam logic [2:0]       c_SH_SHIFT  = 3'b010;
    localparam logic [2:0]       c_SH_CLEAR  = 3'b011;
    localparam logic [1:0]       c_LM1_CLEAR = 2'b01;
    localparam logic [1:0]       c_LM1_LOAD  = 2'b10;
    // The counter is tested for zero before it decrements, so loading
    // WIDTH-1 yields exactly WIDTH shift states.
    localparam logic [CNT_W-1:0] c_CNT_LOAD  = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_next_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
        end
    end

    always_comb begin
        w_next_state = ST_IDLE;
        w_next_count = r_count;
        mulst        = 3'd0;
        alu_sel      = 3'b000;
        hi_sel       = 1'b0;
        lom1_ctl     = 2'b00;
        lo_ctl       = 3'b000;
        hi_ctl       = 3'b000;
        pc_we        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                mulst = 3'd0;
                // Combinational stall: the PC must not advance past the
                // mult in the same cycle it is decoded.
                pc_we = ~start;
                w_next_state = start ? ST_LOAD : ST_IDLE;
            end
            ST_LOAD: begin
                mulst        = 3'd1;
                busy         = 1'b1;
                lo_ctl       = c_SH_LOAD;
                hi_ctl       = c_SH_CLEAR;
                lom1_ctl     = c_LM1_CLEAR;
                w_next_count = c_CNT_LOAD;
                w_next_state = ST_EVAL;
            end
            ST_EVAL: begin
                mulst = 3'd2;
                busy  = 1'b1;
                // Booth recoding of the bit pair {lo[0], lo[-1]}.
                case ({lo0, lo_m1})
                    2'b01: begin
                        alu_sel = c_ALU_ADD;
                        hi_sel  = 1'b1;
                        hi_ctl  = c_SH_LOAD;
                    end
                    2'b10: begin
                        alu_sel = c_ALU_SUB;
                        hi_sel  = 1'b1;
                        hi_ctl  = c_SH_LOAD;
                    end
                    default: begin
                        hi_ctl = 3'b000;
                    end
                endcase
                w_next_state = ST_SHIFT;
            end
            ST_SHIFT: begin
                mulst    = 3'd3;
                busy     = 1'b1;
                // hi, lo and lo[-1] move together as one 65-bit
                // arithmetic right shift.
                hi_ctl   = c_SH_SHIFT;
                lo_ctl   = c_SH_SHIFT;
                lom1_ctl = c_LM1_LOAD;
                if (r_count == '0) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_count = r_count - 1'b1;
                    w_next_state = ST_EVAL;
                end
            end
            ST_DONE: begin
                mulst        = 3'd4;
                done         = 1'b1;
                pc_we        = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                // Unreachable encodings behave as IDLE and recover to it.
                mulst        = 3'd0;
                pc_we        = ~start;
                w_next_state = ST_IDLE;
            end
        endcase

        // An exception abandons the sequence regardless of start.
        if (flush) begin
            w_next_state = ST_IDLE;
            w_next_count = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_sequencer
// Description : Self-checking bench for mult_sequencer. A behavioural hi/lo
//               datapath reacts to the control fields; products are compared
//               against plain signed multiplication and the state trace
//               against the cycle-count formula of the sequence.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mult_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       flush;
    logic       lo0;
    logic       lo_m1;
    logic [2:0] mulst;
    logic [2:0] alu_sel;
    logic       hi_sel;
    logic [1:0] lom1_ctl;
    logic [2:0] lo_ctl;
    logic [2:0] hi_ctl;
    logic       pc_we;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .flush    (flush),
        .lo0      (lo0),
        .lo_m1    (lo_m1),
        .mulst    (mulst),
        .alu_sel  (alu_sel),
        .hi_sel   (hi_sel),
        .lom1_ctl (lom1_ctl),
        .lo_ctl   (lo_ctl),
        .hi_ctl   (hi_ctl),
        .pc_we    (pc_we),
        .busy     (busy),
        .done     (done)
    );

    // ---------------- behavioural datapath ----------------
    // hi is kept as a wide signed value so the hi+/-M step never loses its
    // sign bit (M = -2^31 would overflow a 32-bit accumulator).
    logic [31:0]        m_rs = '0;
    logic [31:0]        m_rt = '0;
    logic signed [63:0] dp_hi = '0;
    logic [31:0]        dp_lo = '0;
    logic               dp_lom1 = 1'b0;
    logic signed [63:0] m_ext;
    logic signed [63:0] alu_a;
    logic signed [63:0] alu_res;

    assign m_ext   = {{32{m_rs[31]}}, m_rs};
    assign alu_a   = hi_sel ? dp_hi : 64'sd0;
    assign alu_res = (alu_sel == 3'b110) ? alu_a - m_ext : alu_a + m_ext;
    assign lo0     = dp_lo[0];
    assign lo_m1   = dp_lom1;

    always @(posedge clk) begin
        case (hi_ctl)
            3'b001:  dp_hi <= alu_res;
            3'b010:  dp_hi <= dp_hi >>> 1;
            3'b011:  dp_hi <= '0;
            default: dp_hi <= dp_hi;
        endcase
        case (lo_ctl)
            3'b001:  dp_lo <= m_rt;
            3'b010:  dp_lo <= {dp_hi[0], dp_lo[31:1]};
            3'b011:  dp_lo <= '0;
            default: dp_lo <= dp_lo;
        endcase
        case (lom1_ctl)
            2'b01:   dp_lom1 <= 1'b0;
            2'b10:   dp_lom1 <= dp_lo[0];
            default: dp_lom1 <= dp_lom1;
        endcase
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Runs one complete multiply starting from IDLE and checks the whole
    // trace: LOAD at cycle 1, EVAL/SHIFT pairs on cycles 2..65, DONE at 66.
    task automatic run_mult(input string tag, input logic [31:0] rs, input logic [31:0] rt,
                            input logic [63:0] exp_p, input logic [2:0] exp_alu,
                            input logic exp_hs);
        int         trace_err;
        int         first_bad;
        int         shifts;
        logic [2:0] exp_st;
        logic       exp_busy;
        logic       exp_done;
        logic       exp_pcwe;
        trace_err = 0;
        first_bad = -1;
        shifts    = 0;
        @(negedge clk);
        m_rs  = rs;
        m_rt  = rt;
        start = 1'b1;
        #1;
        chk({tag, " start-cycle pc_we"}, 64'(pc_we), 64'd0);
        for (int cyc = 1; cyc <= 67; cyc++) begin
            @(negedge clk);
            if (cyc == 1) exp_st = 3'd1;
            else if (cyc <= 65) exp_st = (cyc % 2 == 0) ? 3'd2 : 3'd3;
            else if (cyc == 66) exp_st = 3'd4;
            else exp_st = 3'd0;
            exp_busy = (cyc <= 65);
            exp_done = (cyc == 66);
            exp_pcwe = (cyc >= 66);
            if (mulst !== exp_st || busy !== exp_busy || done !== exp_done || pc_we !== exp_pcwe) begin
                trace_err++;
                if (first_bad < 0) first_bad = cyc;
            end
            if (mulst == 3'd3) shifts++;
            if (cyc == 2) begin
                chk({tag, " first-eval alu_sel"}, 64'(alu_sel), 64'(exp_alu));
                chk({tag, " first-eval hi_sel"}, 64'(hi_sel), 64'(exp_hs));
            end
            if (cyc == 66) chk({tag, " product"}, {dp_hi[31:0], dp_lo}, exp_p);
            if (cyc == 1) start = 1'b0;
        end
        if (trace_err != 0) $display("  %s first bad trace cycle %0d", tag, first_bad);
        chk({tag, " trace errors"}, 64'(trace_err), 64'd0);
        chk({tag, " shift states"}, 64'(shifts), 64'd32);
    endtask

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [63:0] prod;
        logic [2:0]  alu1;
        logic        hs1;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int         evals;
        int         waited;
        logic [31:0] rrs;
        logic [31:0] rrt;
        longint     sa;
        longint     sb;

        vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F, 3'b110, 1'b1};
        vecs[1] = '{32'hFFFF_FFFE, 32'd3,          64'hFFFF_FFFF_FFFF_FFFA, 3'b110, 1'b1};
        vecs[2] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 3'b000, 1'b0};
        vecs[3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 3'b110, 1'b1};
        vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 3'b110, 1'b1};
        vecs[5] = '{32'd0,          32'h1234_5678, 64'h0000_0000_0000_0000, 3'b000, 1'b0};
        vecs[6] = '{32'h8000_0000, 32'd1,          64'hFFFF_FFFF_8000_0000, 3'b110, 1'b1};
        vecs[7] = '{32'd5,          32'h8000_0000, 64'hFFFF_FFFD_8000_0000, 3'b000, 1'b0};

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset mulst", 64'(mulst), 64'd0);
        chk("reset ctl", 64'({alu_sel, hi_sel, lom1_ctl, lo_ctl, hi_ctl}), 64'd0);
        chk("reset busy/done", 64'({busy, done}), 64'd0);
        chk("reset pc_we start=0", 64'(pc_we), 64'd1);
        start = 1'b1;
        #1;
        chk("reset pc_we start=1", 64'(pc_we), 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle after reset", 64'(mulst), 64'd0);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 8; i++) begin
            run_mult($sformatf("vec%0d", i), vecs[i].rs, vecs[i].rt, vecs[i].prod,
                     vecs[i].alu1, vecs[i].hs1);
        end

        // ---------------- random operands vs signed multiply ----------------
        for (int i = 0; i < 12; i++) begin
            rrs = $urandom;
            rrt = $urandom;
            sa  = longint'($signed(rrs));
            sb  = longint'($signed(rrt));
            run_mult($sformatf("rand%0d", i), rrs, rrt, 64'(sa * sb),
                     rrt[0] ? 3'b110 : 3'b000, rrt[0]);
        end

        // ---------------- asynchronous reset at the 20th EVAL ----------------
        @(negedge clk);
        m_rs  = 32'd11;
        m_rt  = 32'd13;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        evals = 0;
        for (int k = 0; k < 80 && evals < 20; k++) begin
            @(negedge clk);
            if (mulst == 3'd2) evals++;
        end
        chk("reached 20th eval", 64'(evals), 64'd20);
        rst_n = 1'b0;
        #1;
        chk("async reset mulst", 64'(mulst), 64'd0);
        chk("async reset ctl", 64'({alu_sel, hi_sel, lom1_ctl, lo_ctl, hi_ctl}), 64'd0);
        chk("async reset busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_mult("after-reset", 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 3'b110, 1'b1);

        // ---------------- flush during SHIFT with start held ----------------
        @(negedge clk);
        m_rs  = 32'd9;
        m_rt  = 32'd11;
        start = 1'b1;
        waited = 0;
        for (int k = 0; k < 10 && mulst != 3'd3; k++) begin
            @(negedge clk);
            waited++;
        end
        chk("reached shift", 64'(mulst), 64'd3);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush -> idle", 64'(mulst), 64'd0);
        chk("flush idle pc_we stalled", 64'(pc_we), 64'd0);
        @(negedge clk);
        chk("restart load", 64'(mulst), 64'd1);
        start = 1'b0;
        waited = 0;
        for (int k = 0; k < 80 && done !== 1'b1; k++) begin
            @(negedge clk);
            waited++;
        end
        chk("restart load-to-done cycles", 64'(waited), 64'd65);
        chk("restart product", {dp_hi[31:0], dp_lo}, 64'd99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
